// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// Per-channel DAC sample source: picks DDS, pattern, DMA, zero, PN7, PN15 or ramp
// and registers one beat of SAMPLES_PER_BEAT 16-bit samples per clock.
module ad_ip_jesd204_tpl_dac_channel_src #(
  parameter int SAMPLES_PER_BEAT = 4
) (
  input  logic                             link_clk,
  input  logic                             dac_rst,
  input  logic                             dac_sync,
  input  logic [3:0]                       dac_data_sel,
  input  logic [15:0]                      dac_pat_data_0,
  input  logic [15:0]                      dac_pat_data_1,
  input  logic [SAMPLES_PER_BEAT*16-1:0]   dds_data,
  input  logic [SAMPLES_PER_BEAT*16-1:0]   dma_data,
  input  logic                             dma_valid,
  output logic                             dma_ready,
  output logic [SAMPLES_PER_BEAT*16-1:0]   dac_data,
  output logic                             dac_dunf
);

  localparam int DW = SAMPLES_PER_BEAT * 16;

  localparam logic [3:0] SEL_DDS  = 4'd0;
  localparam logic [3:0] SEL_PAT  = 4'd1;
  localparam logic [3:0] SEL_DMA  = 4'd2;
  localparam logic [3:0] SEL_PN7  = 4'd6;
  localparam logic [3:0] SEL_PN15 = 4'd7;
  localparam logic [3:0] SEL_RAMP = 4'd10;

  localparam logic [6:0]  PN7_SEED  = 7'h7F;
  localparam logic [14:0] PN15_SEED = 15'h7FFF;

  logic [3:0]    sel_q, sel_d;
  logic [6:0]    pn7_q, pn7_d, pn7_use, pn7_s;
  logic [14:0]   pn15_q, pn15_d, pn15_use, pn15_s;
  logic [15:0]   ramp_q, ramp_d, ramp_use;
  logic [DW-1:0] data_q, data_d;
  logic          dunf_q, dunf_d;
  logic          restart;
  logic [DW-1:0] pn7_beat, pn15_beat, ramp_beat, pat_beat;

  assign dma_ready = !dac_rst && (dac_data_sel == SEL_DMA);
  assign dac_data  = data_q;
  assign dac_dunf  = dunf_q;

  // A select change restarts the generators exactly like a sync pulse.
  assign restart  = dac_sync || (dac_data_sel != sel_q);
  assign pn7_use  = restart ? PN7_SEED  : pn7_q;
  assign pn15_use = restart ? PN15_SEED : pn15_q;
  assign ramp_use = restart ? 16'h0000  : ramp_q;

  genvar gi;
  generate
    for (gi = 0; gi < SAMPLES_PER_BEAT; gi++) begin : g_lane
      assign ramp_beat[16*gi +: 16] = ramp_use + 16'(gi);
      assign pat_beat[16*gi +: 16]  = (gi % 2 == 0) ? dac_pat_data_0 : dac_pat_data_1;
    end
  endgenerate

  // Unrolled LFSRs: the first stream bit lands in the MSB of lane 0.
  always_comb begin
    pn7_s     = pn7_use;
    pn15_s    = pn15_use;
    pn7_beat  = '0;
    pn15_beat = '0;
    for (int k = 0; k < SAMPLES_PER_BEAT; k++) begin
      for (int b = 0; b < 16; b++) begin
        pn7_beat[16*k + 15 - b]  = pn7_s[6];
        pn15_beat[16*k + 15 - b] = pn15_s[14];
        pn7_s  = {pn7_s[5:0], pn7_s[6] ^ pn7_s[5]};
        pn15_s = {pn15_s[13:0], pn15_s[14] ^ pn15_s[13]};
      end
    end
    pn7_d  = pn7_s;
    pn15_d = pn15_s;
  end

  always_comb begin
    sel_d  = dac_data_sel;
    ramp_d = ramp_use + 16'(SAMPLES_PER_BEAT);
    data_d = '0;
    dunf_d = 1'b0;
    case (dac_data_sel)
      SEL_DDS:  data_d = dds_data;
      SEL_PAT:  data_d = pat_beat;
      SEL_DMA: begin
        if (dma_valid) data_d = dma_data;
        else           dunf_d = 1'b1;
      end
      SEL_PN7:  data_d = pn7_beat;
      SEL_PN15: data_d = pn15_beat;
      SEL_RAMP: data_d = ramp_beat;
      default:  data_d = '0;
    endcase
  end

  always_ff @(posedge link_clk) begin
    if (dac_rst) begin
      sel_q  <= 4'd0;
      pn7_q  <= PN7_SEED;
      pn15_q <= PN15_SEED;
      ramp_q <= 16'h0000;
      data_q <= '0;
      dunf_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      pn7_q  <= pn7_d;
      pn15_q <= pn15_d;
      ramp_q <= ramp_d;
      data_q <= data_d;
      dunf_q <= dunf_d;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
// Directed bench for the DAC channel source; a stream-level model predicts every beat.
module tb_ad_ip_jesd204_tpl_dac_channel_src;

  localparam int SPB = 4;
  localparam int DW  = SPB * 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic [3:0]    sel;
  logic [15:0]   pat0, pat1;
  logic [DW-1:0] dds, dma;
  logic          valid;
  logic          ready;
  logic [DW-1:0] dout;
  logic          dunf;

  int nvec  = 0;
  int nfail = 0;

  // Model: PN streams as precomputed maximal-length sequences indexed by position.
  bit          seq7 [0:126];
  bit          seq15[0:32766];
  int          pos7, pos15;
  logic [15:0] mbase;
  logic [3:0]  msel_prev;

  logic [DW-1:0] d0, d2;

  ad_ip_jesd204_tpl_dac_channel_src #(.SAMPLES_PER_BEAT(SPB)) dut (
    .link_clk       (clk),
    .dac_rst        (rst),
    .dac_sync       (sync),
    .dac_data_sel   (sel),
    .dac_pat_data_0 (pat0),
    .dac_pat_data_1 (pat1),
    .dds_data       (dds),
    .dma_data       (dma),
    .dma_valid      (valid),
    .dma_ready      (ready),
    .dac_data       (dout),
    .dac_dunf       (dunf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: check the combinational ready, predict the registered beat, compare after the edge.
  task automatic step();
    logic [DW-1:0] ed;
    logic          eu;
    #1;
    chk("dma_ready", DW'(ready), DW'(!rst && sel == 4'd2));
    ed = '0;
    eu = 1'b0;
    if (rst) begin
      msel_prev = 4'd0;
      pos7      = 0;
      pos15     = 0;
      mbase     = 16'd0;
    end else begin
      if (sync || sel != msel_prev) begin
        pos7  = 0;
        pos15 = 0;
        mbase = 16'd0;
      end
      case (sel)
        4'd0: ed = dds;
        4'd1: for (int k = 0; k < SPB; k++) ed[16*k +: 16] = (k % 2 == 0) ? pat0 : pat1;
        4'd2: if (valid) ed = dma; else eu = 1'b1;
        4'd6: for (int k = 0; k < SPB; k++)
                for (int b = 0; b < 16; b++) ed[16*k + 15 - b] = seq7[(pos7 + 16*k + b) % 127];
        4'd7: for (int k = 0; k < SPB; k++)
                for (int b = 0; b < 16; b++) ed[16*k + 15 - b] = seq15[(pos15 + 16*k + b) % 32767];
        4'd10: for (int k = 0; k < SPB; k++) ed[16*k +: 16] = mbase + 16'(k);
        default: ed = '0;
      endcase
      pos7      = (pos7 + DW) % 127;
      pos15     = (pos15 + DW) % 32767;
      mbase     = mbase + 16'(SPB);
      msel_prev = sel;
    end
    @(posedge clk);
    #1;
    chk("dac_data", dout, ed);
    chk("dac_dunf", DW'(dunf), DW'(eu));
  endtask

  initial begin
    logic [6:0]  s7;
    logic [14:0] s15;
    s7 = 7'h7F;
    for (int j = 0; j < 127; j++) begin
      seq7[j] = s7[6];
      s7 = {s7[5:0], s7[6] ^ s7[5]};
    end
    s15 = 15'h7FFF;
    for (int j = 0; j < 32767; j++) begin
      seq15[j] = s15[14];
      s15 = {s15[13:0], s15[14] ^ s15[13]};
    end
    pos7 = 0; pos15 = 0; mbase = 16'd0; msel_prev = 4'd0;

    rst = 1'b1; sync = 1'b0; sel = 4'd0; pat0 = 16'h0; pat1 = 16'h0;
    dds = '0; dma = '0; valid = 1'b0;
    @(posedge clk);
    step();
    step();
    chk("reset_data", dout, '0);

    // T1: PN7 from reset
    rst = 1'b0; sel = 4'd6;
    step();
    chk("pn7_lane0", DW'(dout[15:0]), DW'(16'hFE04));
    chk("pn7_lane1", DW'(dout[31:16]), DW'(16'h1851));
    repeat (999) step();

    // T2: ramp from reset, sync restart, full wrap
    rst = 1'b1; step();
    rst = 1'b0; sel = 4'd10;
    step();
    chk("ramp_beat0", dout, {16'd3, 16'd2, 16'd1, 16'd0});
    step();
    chk("ramp_beat1", dout, {16'd7, 16'd6, 16'd5, 16'd4});
    repeat (5) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("ramp_sync", dout, {16'd3, 16'd2, 16'd1, 16'd0});
    repeat (16384) step();

    // T3: pattern
    pat0 = 16'hA5A5; pat1 = 16'h5A5A; sel = 4'd1;
    step();
    chk("pattern", dout, {16'h5A5A, 16'hA5A5, 16'h5A5A, 16'hA5A5});
    sync = 1'b1; step(); sync = 1'b0;

    // DDS pass-through
    sel = 4'd0;
    for (int i = 0; i < 3; i++) begin
      dds = {$urandom, $urandom};
      step();
    end

    // T4: DMA valid 1,0,1 then switch to zero
    d0 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    sel = 4'd2; valid = 1'b1; dma = d0;
    step();
    chk("dma_d0", dout, d0);
    valid = 1'b0; dma = {$urandom, $urandom};
    step();
    chk("dma_unf_flag", DW'(dunf), DW'(1'b1));
    valid = 1'b1; dma = d2;
    step();
    chk("dma_d2", dout, d2);
    sel = 4'd3; valid = 1'b0;
    step();
    chk("zero_dunf", DW'(dunf), DW'(1'b0));
    sel = 4'd5;
    step();

    // T5: PN15 -> PN7 -> PN15
    sel = 4'd7;
    step();
    chk("pn15_seed_lane0", DW'(dout[15:0]), DW'(16'hFFFE));
    repeat (4) step();
    sel = 4'd6;
    step();
    chk("switch_pn7_seed", DW'(dout[15:0]), DW'(16'hFE04));
    repeat (3) step();
    sel = 4'd7;
    step();
    chk("switch_pn15_seed", DW'(dout[15:0]), DW'(16'hFFFE));
    repeat (6) step();

    // T6: reset mid-PN15
    rst = 1'b1;
    step();
    chk("mid_reset_data", dout, '0);
    rst = 1'b0;
    step();
    chk("post_reset_seed", DW'(dout[15:0]), DW'(16'hFFFE));
    repeat (3) step();

    // Reset with DMA selected holds ready low
    sel = 4'd2; valid = 1'b1; rst = 1'b1;
    #1;
    chk("ready_in_reset", DW'(ready), DW'(1'b0));
    step();
    rst = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
